// File: rtl/metaball_sched_if.sv
// Pixel result handshake toward the framebuffer writer.
//   pix_valid : pixel result available (master -> slave)
//   pix_ready : downstream accepts pixel (slave -> master)
//   pix_on    : thresholded pixel value
//   pix_addr  : linear pixel address y*H_RES+x
interface metaball_sched_if;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_on;
  logic [31:0] pix_addr;

  modport master (
    output pix_valid,
    output pix_on,
    output pix_addr,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_on,
    input  pix_addr,
    output pix_ready
  );
endinterface

// File: rtl/metaball_sched.sv
// Frame-level scheduler for the lava-lamp metaball array. Raster-scans the frame, broadcasts
// the Q16.15 pixel coordinate to N_BALLS metaball instances, collects their field values,
// saturating-sums them and emits one thresholded pixel per coordinate. One mov_en pulse per
// frame lets the balls advance between frames.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_start       request a frame (only honoured while idle)
//   p_x, p_y, px_stb  coordinate broadcast and evaluation strobe
//   vld, ball_out     per-ball result valid / Q16.15 value (ball i at [32*i+31:32*i])
//   mov_en            per-frame move pulse to the balls
//   busy              scheduler not idle
//   frame_done        end-of-frame pulse
//   timeout_err       sticky: some ball failed to answer within TIMEOUT cycles
//   pix               pixel handshake (master side)
module metaball_sched #(
  parameter int unsigned H_RES   = 64,
  parameter int unsigned V_RES   = 48,
  parameter int unsigned N_BALLS = 4,
  parameter logic [31:0] THRESH  = 32'h0000_8000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  output logic [31:0]            p_x,
  output logic [31:0]            p_y,
  output logic                   px_stb,
  input  logic [N_BALLS-1:0]     vld,
  input  logic [32*N_BALLS-1:0]  ball_out,
  output logic                   mov_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err,
  metaball_sched_if.master       pix
);

  localparam int unsigned IdxW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StWait,
    StAccum,
    StEmit,
    StMove
  } state_e;

  state_e             state_q;
  logic [15:0]        x_q;
  logic [15:0]        y_q;
  logic [N_BALLS-1:0] done_q;
  logic [N_BALLS-1:0] vld_prev_q;
  logic [31:0]        result_q [N_BALLS];
  logic [31:0]        acc_q;
  logic [31:0]        tcnt_q;
  logic [IdxW-1:0]    idx_q;

  logic [N_BALLS-1:0] rise;
  logic [N_BALLS-1:0] done_next;
  logic [31:0]        addend;
  logic [32:0]        acc_sum;
  logic [31:0]        acc_next;
  logic               last_x;
  logic               last_y;
  logic [15:0]        x_next;
  logic [15:0]        y_next;
  logic [31:0]        addr_calc;

  always_comb begin
    // Only a fresh 0->1 transition counts; a vld left high from the previous pixel is stale.
    rise      = vld & ~vld_prev_q;
    done_next = done_q | rise;
    // Negative field values contribute nothing.
    addend    = result_q[idx_q][31] ? 32'h0 : result_q[idx_q];
    acc_sum   = {1'b0, acc_q} + {1'b0, addend};
    acc_next  = (acc_sum > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : acc_sum[31:0];
    last_x    = (x_q == 16'(H_RES - 1));
    last_y    = (y_q == 16'(V_RES - 1));
    x_next    = last_x ? 16'h0 : x_q + 16'd1;
    y_next    = last_x ? y_q + 16'd1 : y_q;
    addr_calc = 32'(y_q) * 32'(H_RES) + 32'(x_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      done_q        <= '0;
      vld_prev_q    <= '0;
      acc_q         <= '0;
      tcnt_q        <= '0;
      idx_q         <= '0;
      for (int i = 0; i < N_BALLS; i++) result_q[i] <= '0;
      p_x           <= '0;
      p_y           <= '0;
      px_stb        <= 1'b0;
      mov_en        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      pix.pix_valid <= 1'b0;
      pix.pix_on    <= 1'b0;
      pix.pix_addr  <= '0;
    end else begin
      vld_prev_q <= vld;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            x_q     <= '0;
            y_q     <= '0;
            p_x     <= '0;
            p_y     <= '0;
            px_stb  <= 1'b1;
            busy    <= 1'b1;
            state_q <= StStrobe;
          end
        end
        StStrobe: begin
          px_stb  <= 1'b0;
          done_q  <= '0;
          acc_q   <= '0;
          tcnt_q  <= '0;
          idx_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          done_q <= done_next;
          tcnt_q <= tcnt_q + 32'd1;
          for (int i = 0; i < N_BALLS; i++) begin
            if (rise[i] && !done_q[i]) result_q[i] <= ball_out[32*i +: 32];
          end
          if (&done_next) begin
            state_q <= StAccum;
          end else if (tcnt_q == 32'(TIMEOUT - 1)) begin
            // Give up on the missing balls: they count as zero field.
            timeout_err <= 1'b1;
            for (int i = 0; i < N_BALLS; i++) begin
              if (!done_next[i]) result_q[i] <= '0;
            end
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_next;
          if (idx_q == IdxW'(N_BALLS - 1)) begin
            pix.pix_valid <= 1'b1;
            pix.pix_on    <= (acc_next >= THRESH);
            pix.pix_addr  <= addr_calc;
            state_q       <= StEmit;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StEmit: begin
          if (pix.pix_ready) begin
            pix.pix_valid <= 1'b0;
            x_q           <= x_next;
            y_q           <= y_next;
            if (last_x && last_y) begin
              mov_en     <= 1'b1;
              frame_done <= 1'b1;
              state_q    <= StMove;
            end else begin
              px_stb  <= 1'b1;
              p_x     <= {1'b0, x_next, 15'b0};
              p_y     <= {1'b0, y_next, 15'b0};
              state_q <= StStrobe;
            end
          end
        end
        StMove: begin
          mov_en     <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_metaball_sched.sv
// Self-checking bench for metaball_sched: stub balls answer a programmable number of cycles
// after each strobe; pixel results are compared against an arithmetic reference of the
// clamp / saturating-sum / threshold rules.
module tb_metaball_sched;
  localparam int H = 2;
  localparam int V = 2;
  localparam int N = 2;
  localparam int T = 64;
  localparam logic [31:0] TH = 32'h0000_8000;
  localparam int NPIX = H * V;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [31:0]    p_x;
  logic [31:0]    p_y;
  logic           px_stb;
  logic [N-1:0]   vld;
  logic [32*N-1:0] ball_out;
  logic           mov_en;
  logic           busy;
  logic           frame_done;
  logic           timeout_err;

  metaball_sched_if pix ();

  metaball_sched #(
    .H_RES   (H),
    .V_RES   (V),
    .N_BALLS (N),
    .THRESH  (TH),
    .TIMEOUT (T)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .p_x         (p_x),
    .p_y         (p_y),
    .px_stb      (px_stb),
    .vld         (vld),
    .ball_out    (ball_out),
    .mov_en      (mov_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .pix         (pix)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-pixel stub plan for the frame being run.
  logic [31:0] val [NPIX][N];
  int          lat [NPIX][N];
  int          stale_ball;
  int          ready_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Field sum: negatives clamp to zero, sum saturates at 0x7FFF_FFFF; the stale ball times out.
  function automatic logic [31:0] ref_acc(input int p);
    longint s;
    longint v;
    s = 0;
    for (int b = 0; b < N; b++) begin
      if (b == stale_ball) continue;
      v = longint'(signed'(val[p][b]));
      if (v < 0) v = 0;
      s += v;
    end
    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  task automatic run_frame(input bit chk_restart);
    int strobes, xfers, movs, dones, cyc, post, stb_cyc, last_rise, cur, low_left;
    int cnt [N];
    bit prev_valid;
    logic [31:0] held_addr;
    logic held_on;
    logic [31:0] exp_acc;
    strobes = 0; xfers = 0; movs = 0; dones = 0; post = 0;
    stb_cyc = 0; last_rise = 0; cur = 0; low_left = 0; prev_valid = 0;
    held_addr = '0; held_on = 1'b0;
    for (int b = 0; b < N; b++) cnt[b] = 0;
    frame_start = 1'b1;
    for (cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (px_stb) begin
        check_eq("stb_px", p_x, {1'b0, 16'(strobes % H), 15'b0});
        check_eq("stb_py", p_y, {1'b0, 16'(strobes / H), 15'b0});
        check_eq("stb_vs_mov", 32'(mov_en), 32'd0);
        stb_cyc   = cyc;
        last_rise = cyc;
        cur       = (strobes < NPIX) ? strobes : NPIX - 1;
        for (int b = 0; b < N; b++) cnt[b] = lat[cur][b] + 1;
        strobes++;
      end
      if (pix.pix_valid) begin
        check_eq("valid_no_stb", 32'(px_stb), 32'd0);
        if (!prev_valid) begin
          if (xfers < NPIX) begin
            exp_acc = ref_acc(xfers);
            check_eq("pix_on", 32'(pix.pix_on), 32'(exp_acc >= TH));
            check_eq("pix_addr", pix.pix_addr, 32'(xfers));
          end else begin
            check_eq("extra_pixel", 32'(xfers), 32'(NPIX - 1));
          end
          if (stale_ball >= 0) check_eq("latency_to", 32'(cyc - stb_cyc), 32'(T + N + 1));
          else                 check_eq("latency", 32'(cyc - last_rise), 32'(N + 1));
          check_eq("timeout_err", 32'(timeout_err), 32'(stale_ball >= 0));
          held_addr = pix.pix_addr;
          held_on   = pix.pix_on;
          low_left  = (ready_mode == 1 && xfers == 1) ? 5 : 0;
        end else begin
          check_eq("hold_addr", pix.pix_addr, held_addr);
          check_eq("hold_on", 32'(pix.pix_on), 32'(held_on));
        end
      end
      if (mov_en) begin
        check_eq("mov_with_done", 32'(frame_done), 32'd1);
        check_eq("mov_after_last", 32'(xfers), 32'(NPIX));
        movs++;
        if (chk_restart) frame_start = 1'b1;
      end
      if (frame_done) dones++;
      if (chk_restart && strobes == 1 && cyc == stb_cyc + 1) frame_start = 1'b1;

      // Stub balls.
      for (int b = 0; b < N; b++) begin
        if (b == stale_ball) begin
          vld[b] = 1'b1;
          ball_out[32*b +: 32] = val[0][b];
        end else if (cnt[b] > 0) begin
          cnt[b]--;
          if (cnt[b] == 0) begin
            vld[b] = 1'b1;
            ball_out[32*b +: 32] = val[cur][b];
            last_rise = cyc;
          end else begin
            vld[b] = 1'b0;
            ball_out[32*b +: 32] = $urandom;
          end
        end else begin
          vld[b] = 1'b0;
          ball_out[32*b +: 32] = $urandom;
        end
      end

      // Downstream ready.
      if (pix.pix_valid) begin
        if (ready_mode == 0) begin
          pix.pix_ready = 1'b1;
        end else if (ready_mode == 1) begin
          if (low_left > 0) begin
            pix.pix_ready = 1'b0;
            low_left--;
          end else begin
            pix.pix_ready = 1'b1;
          end
        end else begin
          pix.pix_ready = ($urandom_range(0, 3) != 0);
        end
        if (pix.pix_ready) xfers++;
        prev_valid = !pix.pix_ready;
      end else begin
        pix.pix_ready = 1'($urandom_range(0, 1));
        prev_valid = 1'b0;
      end

      if (dones > 0) post++;
      if (post > 20) break;
    end
    frame_start = 1'b0;
    check_eq("frame_finished", 32'(dones > 0), 32'd1);
    check_eq("frame_done_cnt", 32'(dones), 32'd1);
    check_eq("mov_en_cnt", 32'(movs), 32'd1);
    check_eq("strobe_cnt", 32'(strobes), 32'(NPIX));
    check_eq("xfer_cnt", 32'(xfers), 32'(NPIX));
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_wait();
    int seen;
    bit activity;
    seen = 0;
    vld = '0;
    frame_start = 1'b1;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (px_stb) seen = 1;
    end
    check_eq("rst_test_stb", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_px_stb", 32'(px_stb), 32'd0);
    check_eq("rst_pix_valid", 32'(pix.pix_valid), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_mov_en", 32'(mov_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    activity = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (busy || px_stb || pix.pix_valid || mov_en || frame_done) activity = 1'b1;
    end
    check_eq("post_rst_quiet", 32'(activity), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    vld = '0;
    ball_out = '0;
    pix.pix_ready = 1'b0;
    stale_ball = -1;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_px_stb", 32'(px_stb), 32'd0);
    check_eq("reset_p_x", p_x, 32'd0);
    check_eq("reset_p_y", p_y, 32'd0);
    check_eq("reset_mov_en", 32'(mov_en), 32'd0);
    check_eq("reset_frame_done", 32'(frame_done), 32'd0);
    check_eq("reset_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("reset_pix_valid", 32'(pix.pix_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed frame: threshold edge, saturation, negative clamp, backpressure on pixel 1,
    // ignored frame_start in WAIT and MOVE.
    val[0][0] = 32'h0000_4000; val[0][1] = 32'h0000_3FFF;
    val[1][0] = 32'h0000_4000; val[1][1] = 32'h0000_4000;
    val[2][0] = 32'h7FFF_0000; val[2][1] = 32'h7FFF_0000;
    val[3][0] = 32'hFFFF_8000; val[3][1] = 32'h0000_7FFF;
    for (int p = 0; p < NPIX; p++) for (int b = 0; b < N; b++) lat[p][b] = 3;
    ready_mode = 1;
    run_frame(1'b1);

    // Stale vld on ball 1: every pixel times out and ball 1 counts as zero.
    for (int p = 0; p < NPIX; p++) begin
      val[p][0] = 32'h0000_4000;
      val[p][1] = 32'h0000_4000;
    end
    stale_ball = 1;
    ready_mode = 0;
    vld[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(1'b0);
    check_eq("timeout_sticky", 32'(timeout_err), 32'd1);
    stale_ball = -1;

    reset_mid_wait();

    // Randomized frames.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        for (int b = 0; b < N; b++) begin
          case ($urandom_range(0, 3))
            0:       val[p][b] = $urandom_range(0, 32'h6000);
            1:       val[p][b] = $urandom;
            2:       val[p][b] = 32'h0000_8000 - $urandom_range(0, 2);
            default: val[p][b] = 32'h7FFF_0000 + $urandom_range(0, 32'hFFFF);
          endcase
          lat[p][b] = $urandom_range(1, 8);
        end
      end
      run_frame(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
